// File: rtl/mem_serial_out.sv
// Fetches the byte at memAddr and shifts it out MSB-first on the serial clock.
// byteDone pulses after the last bit so the program counter can advance.
module mem_serial_out #(
  parameter int unsigned addrWidth  = 16,
  parameter int unsigned dataWidth  = 8,
  parameter int unsigned memLatency = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sclkPosEdge,
  input  logic                 sclkNegEdge,
  input  logic                 enable,
  input  logic [addrWidth-1:0] memAddr,
  input  logic [dataWidth-1:0] memData,
  output logic                 memRead,
  output logic                 sout,
  output logic                 byteDone,
  output logic                 busy,
  output logic                 underrun
);
  localparam int unsigned CntW = (dataWidth > 1) ? $clog2(dataWidth) : 1;
  localparam int unsigned LatW = 3;
  localparam logic [CntW-1:0] LastBit = CntW'(dataWidth - 1);
  localparam logic [LatW-1:0] LatLast = LatW'(memLatency);

  typedef enum logic [2:0] {StIdle, StSettle, StFetch, StLoad, StShift} state_e;

  state_e               state_q, state_d;
  logic [dataWidth-1:0] shift_q, shift_d;
  logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [LatW-1:0]      lat_cnt_q, lat_cnt_d;
  logic                 sout_q, sout_d;
  logic                 mem_read_q, mem_read_d;
  logic                 byte_done_q, byte_done_d;
  logic                 underrun_q, underrun_d;
  logic                 first_q, first_d;
  logic                 neg_only;

  // The address goes straight to memory; this block never looks at it.
  logic unused_addr;
  assign unused_addr = ^memAddr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      lat_cnt_q   <= '0;
      sout_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      byte_done_q <= 1'b0;
      underrun_q  <= 1'b0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      sout_q      <= sout_d;
      mem_read_q  <= mem_read_d;
      byte_done_q <= byte_done_d;
      underrun_q  <= underrun_d;
      first_q     <= first_d;
    end
  end

  always_comb begin
    // A coincident posedge wins; the negedge strobe is dropped.
    neg_only    = sclkNegEdge & ~sclkPosEdge;
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    sout_d      = sout_q;
    underrun_d  = underrun_q;
    first_d     = first_q;
    mem_read_d  = 1'b0;
    byte_done_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StSettle;
          first_d = 1'b1;
        end
      end
      StSettle: begin
        mem_read_d = 1'b1;
        lat_cnt_d  = '0;
        state_d    = StFetch;
        if (neg_only && !first_q) underrun_d = 1'b1;
      end
      StFetch: begin
        if (neg_only && !first_q) underrun_d = 1'b1;
        if (lat_cnt_q == LatLast) begin
          shift_d = memData;
          state_d = StLoad;
        end else begin
          lat_cnt_d = lat_cnt_q + LatW'(1);
        end
      end
      StLoad: begin
        if (neg_only) begin
          sout_d    = shift_q[dataWidth-1];
          bit_cnt_d = '0;
          first_d   = 1'b0;
          state_d   = StShift;
        end
      end
      StShift: begin
        if (sclkPosEdge && bit_cnt_q == LastBit) begin
          byte_done_d = 1'b1;
          state_d     = enable ? StSettle : StIdle;
        end else if (neg_only && bit_cnt_q != LastBit) begin
          shift_d   = shift_q << 1;
          sout_d    = shift_q[dataWidth-2];
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign memRead  = mem_read_q;
  assign sout     = sout_q;
  assign byteDone = byte_done_q;
  assign underrun = underrun_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_mem_serial_out.sv
// Bench for mem_serial_out: two instances (memLatency 1 and 4) each with a PC and memory model,
// a shared serial clock strobe generator, and a scoreboard of expected bytes.
module tb_mem_serial_out;
  localparam logic [15:0] LastAddr = 16'd127;
  localparam logic [15:0] WrapAddr = 16'd93;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sclk_pos = 1'b0;
  logic        sclk_neg = 1'b0;
  logic        sclk = 1'b0;
  logic        en [2];
  logic [15:0] addr [2];
  logic [7:0]  mdata [2];
  logic        mread [2];
  logic        sout [2];
  logic        bdone [2];
  logic        busy [2];
  logic        urun [2];

  logic [7:0]  mem0 [128];
  logic [7:0]  mem1 [128];
  logic [8:0]  pipe0 [5];
  logic [8:0]  pipe1 [5];
  logic [7:0]  win;
  logic [7:0]  exp_q [$];
  logic [7:0]  obs_q [$];
  int          rd_cnt [2];
  int          bd_cnt [2];
  int          sel = 0;
  int unsigned div = 2;
  int unsigned div_cnt = 0;
  int          checks = 0;
  int          failures = 0;

  mem_serial_out #(.addrWidth(16), .dataWidth(8), .memLatency(1)) dut_l1 (
    .clk(clk), .reset(reset), .sclkPosEdge(sclk_pos), .sclkNegEdge(sclk_neg), .enable(en[0]),
    .memAddr(addr[0]), .memData(mdata[0]), .memRead(mread[0]), .sout(sout[0]),
    .byteDone(bdone[0]), .busy(busy[0]), .underrun(urun[0])
  );

  mem_serial_out #(.addrWidth(16), .dataWidth(8), .memLatency(4)) dut_l4 (
    .clk(clk), .reset(reset), .sclkPosEdge(sclk_pos), .sclkNegEdge(sclk_neg), .enable(en[1]),
    .memAddr(addr[1]), .memData(mdata[1]), .memRead(mread[1]), .sout(sout[1]),
    .byteDone(bdone[1]), .busy(busy[1]), .underrun(urun[1])
  );

  always #5 clk = ~clk;

  // Environment: receiver, PC and memory models, and serial clock (toggles every 2**div clks).
  initial begin
    for (int a = 0; a < 128; a++) begin
      mem0[a] = 8'(a) ^ 8'hA5;
      mem1[a] = 8'(a) ^ 8'hA5;
    end
    for (int k = 0; k < 5; k++) begin
      pipe0[k] = '0;
      pipe1[k] = '0;
    end
    en[0] = 1'b0; en[1] = 1'b0; addr[0] = '0; addr[1] = '0;
    mdata[0] = '0; mdata[1] = '0; win = '0;
    rd_cnt = '{0, 0}; bd_cnt = '{0, 0};
    forever begin
      @(negedge clk);
      if (sclk_pos) win = {win[6:0], sout[sel]};
      if (bdone[sel] === 1'b1) obs_q.push_back(win);
      for (int i = 0; i < 2; i++) begin
        if (mread[i] === 1'b1) rd_cnt[i]++;
        if (bdone[i] === 1'b1) bd_cnt[i]++;
      end
      for (int k = 4; k > 0; k--) begin
        pipe0[k] = pipe0[k-1];
        pipe1[k] = pipe1[k-1];
      end
      pipe0[0] = {mread[0] === 1'b1, mem0[addr[0][6:0]]};
      pipe1[0] = {mread[1] === 1'b1, mem1[addr[1][6:0]]};
      mdata[0] = pipe0[1][8] ? pipe0[1][7:0] : 8'h00;
      mdata[1] = pipe1[4][8] ? pipe1[4][7:0] : 8'h00;
      for (int i = 0; i < 2; i++) begin
        if (bdone[i] === 1'b1) addr[i] = (addr[i] == LastAddr) ? WrapAddr : addr[i] + 16'd1;
      end
      sclk_pos = 1'b0;
      sclk_neg = 1'b0;
      div_cnt++;
      if (div_cnt >= (32'd1 << div)) begin
        div_cnt = 0;
        sclk = ~sclk;
        if (sclk) sclk_pos = 1'b1;
        else sclk_neg = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic start_test(input int s, input int unsigned d);
    en[0] = 1'b0;
    en[1] = 1'b0;
    sel = s;
    div = d;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    obs_q.delete();
    rd_cnt = '{0, 0};
    bd_cnt = '{0, 0};
    addr[0] = '0;
    addr[1] = '0;
  endtask

  task automatic wait_bytes(input int i, input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      #1;
      if (bd_cnt[i] >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_read(input int i, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      #1;
      if (mread[i] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    start_test(0, 2);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (sout[i] !== 1'b0) begin failures++; $display("FAIL reset_sout[%0d] got=%b exp=0", i, sout[i]); end
      checks++;
      if (bdone[i] !== 1'b0) begin failures++; $display("FAIL reset_bdone[%0d] got=%b exp=0", i, bdone[i]); end
      checks++;
      if (busy[i] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d] got=%b exp=0", i, busy[i]); end
      checks++;
      if (mread[i] !== 1'b0) begin failures++; $display("FAIL reset_mread[%0d] got=%b exp=0", i, mread[i]); end
      checks++;
      if (urun[i] !== 1'b0) begin failures++; $display("FAIL reset_urun[%0d] got=%b exp=0", i, urun[i]); end
    end
  endtask

  task automatic test_first_byte();
    bit ok;
    logic [7:0] e, o;
    start_test(0, 2);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'hA4);
    en[0] = 1'b1;
    wait_bytes(0, 1, 2000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL first_done got=timeout exp=byteDone"); end
    checks++;
    if (rd_cnt[0] != 1) begin failures++; $display("FAIL first_reads got=%0d exp=1", rd_cnt[0]); end
    checks++;
    if (addr[0] !== 16'd1) begin failures++; $display("FAIL first_pc got=%0d exp=1", addr[0]); end
    en[0] = 1'b0;
    wait_bytes(0, 2, 2000, ok);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      checks++;
      if (o !== e) begin failures++; $display("FAIL first_byte got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_stream();
    bit ok;
    logic [7:0] e, o;
    start_test(0, 2);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(k) ^ 8'hA5);
    en[0] = 1'b1;
    wait_bytes(0, 3, 3000, ok);
    en[0] = 1'b0;
    wait_bytes(0, 4, 2000, ok);
    repeat (200) @(posedge clk);
    #1;
    checks++;
    if (bd_cnt[0] != 4) begin failures++; $display("FAIL stream_done got=%0d exp=4", bd_cnt[0]); end
    checks++;
    if (rd_cnt[0] != 4) begin failures++; $display("FAIL stream_reads got=%0d exp=4", rd_cnt[0]); end
    checks++;
    if (urun[0] !== 1'b0) begin failures++; $display("FAIL stream_urun got=%b exp=0", urun[0]); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      checks++;
      if (o !== e) begin failures++; $display("FAIL stream_byte got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_underrun();
    bit ok;
    logic [7:0] e, o;
    start_test(1, 1);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'hA4);
    en[1] = 1'b1;
    wait_bytes(1, 1, 2000, ok);
    checks++;
    if (urun[1] !== 1'b0) begin failures++; $display("FAIL urun_first got=%b exp=0", urun[1]); end
    en[1] = 1'b0;
    wait_bytes(1, 2, 2000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL urun_done got=timeout exp=byteDone"); end
    checks++;
    if (urun[1] !== 1'b1) begin failures++; $display("FAIL urun_set got=%b exp=1", urun[1]); end
    checks++;
    if (rd_cnt[1] != 2) begin failures++; $display("FAIL urun_reads got=%0d exp=2", rd_cnt[1]); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      checks++;
      if (o !== e) begin failures++; $display("FAIL urun_byte got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    logic [7:0] e, o;
    start_test(0, 2);
    exp_q.push_back(8'hA5);
    en[0] = 1'b1;
    wait_read(0, 200, ok);
    repeat (32) @(posedge clk);
    #1;
    en[0] = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk);
      #1;
      if (bdone[0] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL drop_done got=timeout exp=byteDone"); end
    @(posedge clk);
    #1;
    checks++;
    if (busy[0] !== 1'b0) begin failures++; $display("FAIL drop_busy got=%b exp=0", busy[0]); end
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (rd_cnt[0] != 1) begin failures++; $display("FAIL drop_reads got=%0d exp=1", rd_cnt[0]); end
    checks++;
    if (bd_cnt[0] != 1) begin failures++; $display("FAIL drop_pulses got=%0d exp=1", bd_cnt[0]); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      checks++;
      if (o !== e) begin failures++; $display("FAIL drop_byte got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] e, o;
    start_test(0, 2);
    en[0] = 1'b1;
    wait_read(0, 200, ok);
    repeat (44) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (sout[0] !== 1'b0) begin failures++; $display("FAIL rmid_sout got=%b exp=0", sout[0]); end
    checks++;
    if (bdone[0] !== 1'b0) begin failures++; $display("FAIL rmid_bdone got=%b exp=0", bdone[0]); end
    checks++;
    if (busy[0] !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy[0]); end
    checks++;
    if (urun[0] !== 1'b0) begin failures++; $display("FAIL rmid_urun got=%b exp=0", urun[0]); end
    wait_read(0, 50, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rmid_refetch got=timeout exp=memRead"); end
    en[0] = 1'b0;
    exp_q.push_back(8'hA5);
    wait_bytes(0, 1, 2000, ok);
    checks++;
    if (bd_cnt[0] != 1) begin failures++; $display("FAIL rmid_pulses got=%0d exp=1", bd_cnt[0]); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      checks++;
      if (o !== e) begin failures++; $display("FAIL rmid_byte got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [7:0] e, o;
    start_test(0, 2);
    mem0[127] = 8'h3C;
    mem0[93] = 8'hC3;
    addr[0] = LastAddr;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    en[0] = 1'b1;
    wait_bytes(0, 1, 2000, ok);
    en[0] = 1'b0;
    wait_bytes(0, 2, 2000, ok);
    checks++;
    if (addr[0] !== 16'd94) begin failures++; $display("FAIL wrap_pc got=%0d exp=94", addr[0]); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      checks++;
      if (o !== e) begin failures++; $display("FAIL wrap_byte got=%h exp=%h", o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_first_byte();
    test_stream();
    test_underrun();
    test_enable_drop();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
